// File: rtl/bcd_operand_loader.sv
// ---------------------------------------------------------------------------
// bcd_operand_loader
//   Edge-clocked operand entry stage for the two-operand BCD adder. A bouncing
//   active-low pushbutton is synchronised and debounced. Each accepted press
//   validates the packed BCD switch value and captures operand A, then
//   operand B. A third press clears both operands.
//
// Ports
//   CLK    in   1  single clock, rising edge
//   RST_N  in   1  asynchronous active-low reset
//   Num    in   8  packed BCD switches ([7:4] tens, [3:0] units)
//   KEY_N  in   1  pushbutton, active-low, asynchronous, bouncing
//   A      out  8  captured operand A
//   B      out  8  captured operand B
//   VALID  out  1  both operands hold accepted values (DONE state)
//   ERR    out  1  sticky: last press rejected because Num was not BCD
//   STATE  out  2  current FSM state (0 WAIT_A, 1 WAIT_B, 2 DONE)
// ---------------------------------------------------------------------------
module bcd_operand_loader #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] Num,
    input  logic       KEY_N,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       VALID,
    output logic       ERR,
    output logic [1:0] STATE
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    // Terminal count: the level is accepted on the edge where the count
    // would reach DEB_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    // Packed BCD validity: both nibbles must be 0..9.
    function automatic logic is_bcd(input logic [7:0] val);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9);
    endfunction

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          arm_q;
    logic          arm_d;
    logic [CW-1:0] rel_cnt_q;
    logic [CW-1:0] rel_cnt_d;
    logic          press_q;
    logic          press_d;

    state_t        state_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic          valid_q;
    logic          err_q;

    // Debounce next-state: count consecutive disagreeing cycles, accept the
    // new level after DEB_CYCLES of them, restart on any agreement.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Arming: after reset a press is only honoured once a released button
    // has been seen. Either the button reads released and debounced for
    // DEB_CYCLES cycles, or a debounced rise occurs (button held through reset).
    always_comb begin
        arm_d     = arm_q;
        rel_cnt_d = rel_cnt_q;
        if (arm_q) begin
            rel_cnt_d = CNT_ZERO;
        end else if (deb_d && !deb_q) begin
            arm_d     = 1'b1;
            rel_cnt_d = CNT_ZERO;
        end else if (sync2_q && deb_q) begin
            if (rel_cnt_q == CNT_LAST) begin
                arm_d     = 1'b1;
                rel_cnt_d = CNT_ZERO;
            end else begin
                rel_cnt_d = rel_cnt_q + CNT_ONE;
            end
        end else begin
            rel_cnt_d = CNT_ZERO;
        end
    end

    // Press pulse: one cycle, the cycle after the debounced level falls.
    always_comb begin
        press_d = deb_prev_q & ~deb_q & arm_q;
    end

    // Button path registers: synchroniser, debouncer, arming and press pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= CNT_ZERO;
            arm_q      <= 1'b0;
            rel_cnt_q  <= CNT_ZERO;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= KEY_N;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            rel_cnt_q  <= rel_cnt_d;
            press_q    <= press_d;
        end
    end

    // Operand FSM with registered outputs; acts only on press cycles except
    // for recovery from the unused encoding.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= WAIT_A;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (press_q) begin
                        if (is_bcd(Num)) begin
                            a_q     <= Num;
                            b_q     <= 8'h00;
                            err_q   <= 1'b0;
                            state_q <= WAIT_B;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                WAIT_B: begin
                    if (press_q) begin
                        if (is_bcd(Num)) begin
                            b_q     <= Num;
                            err_q   <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Restart ignores Num entirely, even if it is not BCD.
                    if (press_q) begin
                        a_q     <= 8'h00;
                        b_q     <= 8'h00;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    a_q     <= 8'h00;
                    b_q     <= 8'h00;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_bcd_operand_loader
//   Directed bench for bcd_operand_loader with DEB_CYCLES = 4. Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_bcd_operand_loader;

    localparam int DEB = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] Num;
    logic       KEY_N;
    logic [7:0] A;
    logic [7:0] B;
    logic       VALID;
    logic       ERR;
    logic [1:0] STATE;

    int vectors = 0;
    int errors  = 0;
    int npress;
    int first_lat;

    bcd_operand_loader #(.DEB_CYCLES(DEB)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Num   (Num),
        .KEY_N (KEY_N),
        .A     (A),
        .B     (B),
        .VALID (VALID),
        .ERR   (ERR),
        .STATE (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (dut.press_q === 1'b1) npress++;
        end
    endtask

    // Press with Num held for 'hold' cycles, then release and let the
    // release debounce complete. Counts press pulses and first latency.
    task automatic do_press(input logic [7:0] num, input int hold);
        Num       = num;
        KEY_N     = 1'b0;
        npress    = 0;
        first_lat = -1;
        for (int i = 1; i <= hold; i++) begin
            @(posedge CLK);
            #1;
            if (dut.press_q === 1'b1) begin
                npress++;
                if (first_lat < 0) first_lat = i;
            end
        end
        KEY_N = 1'b1;
        cycles(12);
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                            input logic ev, input logic ee, input logic [1:0] es);
        chk({tag, ".A"},     A,              ea);
        chk({tag, ".B"},     B,              eb);
        chk({tag, ".VALID"}, {7'd0, VALID},  {7'd0, ev});
        chk({tag, ".ERR"},   {7'd0, ERR},    {7'd0, ee});
        chk({tag, ".STATE"}, {6'd0, STATE},  {6'd0, es});
    endtask

    initial begin
        RST_N = 1'b0;
        KEY_N = 1'b1;
        Num   = 8'h00;
        npress = 0;
        first_lat = -1;
        #1;
        cycles(3);
        chk_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        RST_N = 1'b1;
        cycles(10);

        // Normal entry
        do_press(8'h47, 10);
        chk("entryA.npress", 8'(npress), 8'd1);
        chk("entryA.latency", {7'd0, (first_lat >= DEB + 3) && (first_lat <= DEB + 4)}, 8'd1);
        chk_outs("entryA", 8'h47, 8'h00, 1'b0, 1'b0, 2'd1);
        do_press(8'h38, 10);
        chk("entryB.npress", 8'(npress), 8'd1);
        chk("entryB.latency", {7'd0, (first_lat >= DEB + 3) && (first_lat <= DEB + 4)}, 8'd1);
        chk_outs("entryB", 8'h47, 8'h38, 1'b1, 1'b0, 2'd2);

        // Asynchronous reset from DONE, checked before any clock edge
        RST_N = 1'b0;
        #2;
        chk_outs("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        cycles(2);
        RST_N = 1'b1;
        cycles(10);

        // Bounce rejection
        Num    = 8'h66;
        npress = 0;
        for (int k = 0; k < 5; k++) begin
            KEY_N = 1'b0;
            cycles(2);
            KEY_N = 1'b1;
            cycles(2);
        end
        cycles(8);
        chk("bounce.npress", 8'(npress), 8'd0);
        chk_outs("bounce", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        do_press(8'h12, 10);
        chk("bounce_clean.npress", 8'(npress), 8'd1);
        chk_outs("bounce_clean", 8'h12, 8'h00, 1'b0, 1'b0, 2'd1);

        // Complete, then restart from DONE with non-BCD switches
        do_press(8'h34, 10);
        chk_outs("done2", 8'h12, 8'h34, 1'b1, 1'b0, 2'd2);
        do_press(8'hFF, 10);
        chk("restart.npress", 8'(npress), 8'd1);
        chk_outs("restart", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

        // Invalid BCD in WAIT_A, then a valid boundary value
        do_press(8'h5A, 10);
        chk_outs("badA", 8'h00, 8'h00, 1'b0, 1'b1, 2'd0);
        do_press(8'h99, 10);
        chk_outs("goodA99", 8'h99, 8'h00, 1'b0, 1'b0, 2'd1);

        // Invalid tens digit in WAIT_B, then valid
        do_press(8'hA0, 10);
        chk_outs("badB", 8'h99, 8'h00, 1'b0, 1'b1, 2'd1);
        do_press(8'h05, 10);
        chk_outs("goodB", 8'h99, 8'h05, 1'b1, 1'b0, 2'd2);
        do_press(8'h00, 10);
        chk_outs("restart2", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

        // Held button: one transition only
        do_press(8'h21, 100);
        chk("held.npress", 8'(npress), 8'd1);
        chk_outs("held", 8'h21, 8'h00, 1'b0, 1'b0, 2'd1);
        do_press(8'h55, 10);
        chk_outs("held_next", 8'h21, 8'h55, 1'b1, 1'b0, 2'd2);

        // Reset while the button is held: no press until released and re-pressed
        KEY_N = 1'b0;
        cycles(3);
        RST_N = 1'b0;
        #2;
        chk_outs("held_reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        cycles(2);
        RST_N  = 1'b1;
        Num    = 8'h77;
        npress = 0;
        cycles(30);
        chk("held_reset.npress", 8'(npress), 8'd0);
        chk("held_reset.STATE", {6'd0, STATE}, 8'd0);
        KEY_N = 1'b1;
        cycles(12);
        chk("held_reset_rel.npress", 8'(npress), 8'd0);
        do_press(8'h77, 10);
        chk("after_reset.npress", 8'(npress), 8'd1);
        chk_outs("after_reset", 8'h77, 8'h00, 1'b0, 1'b0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bcd_operand_loader.md
# bcd_operand_loader

Synchronous operand-entry stage placed directly upstream of the two-operand BCD adder and 7-segment display path. It replaces the clock-phase latch pair with an edge-clocked loader. The user sets 8-bit packed BCD on the switches (`Num`) and presses a pushbutton (`KEY_N`). The block debounces the button, validates the BCD, and captures operand A and then operand B. It then presents both operands with a `VALID` flag to the downstream adder.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles required before a button level change is accepted (10 ms at 50 MHz). Legal range is ≥2. The counter width is ceil(log2(DEB_CYCLES+1)).
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST_N` input, 1 bit: reset, asynchronous assert, active-low.
- `Num` input, 8 bits: packed BCD from the switches. `[7:4]` is the tens digit, `[3:0]` the units digit. Treated as quasi-static and sampled only on an accepted press.
- `KEY_N` input, 1 bit: pushbutton, active-low, asynchronous to `CLK`, bouncing.
- `A` output, 8 bits: captured operand A (packed BCD).
- `B` output, 8 bits: captured operand B (packed BCD).
- `VALID` output, 1 bit: high while both A and B hold accepted operands.
- `ERR` output, 1 bit: sticky flag; the last press was rejected because `Num` was not BCD.
- `STATE` output, 2 bits: current FSM state, for LED/debug use.

## Operation
**Reset** (`RST_N` low, asynchronous):
- `A`=0, `B`=0, `VALID`=0, `ERR`=0, `STATE`=WAIT_A (2'd0).
- Synchronizer flops = 1, debounced level = 1 (released), debounce counter = 0.

**Button path:**
- Two-flop synchronizer on `KEY_N` produces `key_s`.
- Debounce:
  - `deb` holds the accepted level. The counter increments each cycle that `key_s` != `deb` and clears to 0 whenever `key_s` == `deb`.
  - When the counter reaches `DEB_CYCLES`, `deb` <= `key_s` and the counter clears.
  - Any bounce shorter than `DEB_CYCLES` cycles is ignored.
- `press` is a one-cycle pulse, registered, asserted the cycle after `deb` goes 1→0. Holding the button produces exactly one press. The next press requires a debounced release first.

**BCD check:** `Num` is valid iff `Num[7:4]` ≤ 9 and `Num[3:0]` ≤ 9.

**FSM** (only acts on cycles with `press`=1):
- WAIT_A (0):
  - Valid `Num`: `A`<=`Num`, `B`<=0, `ERR`<=0, go to WAIT_B.
  - Invalid: `ERR`<=1, stay; `A` unchanged.
- WAIT_B (1):
  - Valid: `B`<=`Num`, `ERR`<=0, `VALID`<=1, go to DONE.
  - Invalid: `ERR`<=1, stay.
- DONE (2):
  - Any press, regardless of `Num` validity: `A`<=0, `B`<=0, `VALID`<=0, `ERR`<=0, go to WAIT_A. `Num` is not captured.
- Encoding 3 is unreachable. If it is entered, the FSM goes to WAIT_A on the next clock with outputs cleared.

**Output stability:**
- `A`/`B` change only on the press-cycle transitions listed above.
- Between presses the downstream adder sees stable operands.
- `VALID` is high only in DONE.

## Timing
- Press latency: `KEY_N` falls and stays low; `deb` falls DEB_CYCLES+2 or DEB_CYCLES+3 rising edges later (synchronizer uncertainty). `press` follows one cycle after `deb` falls, and `A`/`B`/`VALID`/`ERR`/`STATE` update on the edge that ends the `press` cycle.
- All outputs are registered; there is no combinational path from `Num` or `KEY_N` to any output.
- `Num` is sampled on the single `press` cycle. A change of `Num` on that same cycle is captured if it is settled before the edge.
- Reset asserted mid-debounce or mid-sequence: everything returns to reset values immediately. After release, a still-held button must first debounce high, then low, before a press is produced.
- Release is synchronous in effect: the first state change after `RST_N` rises occurs no earlier than the second `CLK` edge.

## Test plan
All scenarios use `DEB_CYCLES`=4.
1. **Reset:** assert `RST_N`=0 mid-run with `STATE`=DONE → `A`=0x00, `B`=0x00, `VALID`=0, `ERR`=0, `STATE`=0 immediately, without waiting for a clock.
2. **Normal entry:**
   - `Num`=0x47, clean press held 10 cycles → `A`=0x47, `STATE`=1.
   - Release, then `Num`=0x38, press → `B`=0x38, `VALID`=1, `STATE`=2.
   - Confirm `press` is asserted exactly once per press, in the window DEB_CYCLES+3 to DEB_CYCLES+4 cycles after the fall.
3. **Bounce rejection:**
   - `KEY_N` toggles low/high every 2 cycles for 20 cycles, then returns high → no `press`, no state change.
   - Then a clean 10-cycle low → exactly one `press`.
4. **Invalid BCD:**
   - In WAIT_A with `Num`=0x5A, press → `ERR`=1, `A` unchanged (0x00), `STATE`=0.
   - Then `Num`=0x99, press → `A`=0x99, `ERR`=0, `STATE`=1.
5. **Restart from DONE:** in DONE with `Num`=0xFF, press → `A`=0, `B`=0, `VALID`=0, `ERR`=0, `STATE`=0.
6. **Held button:** hold `KEY_N` low for 100 cycles in WAIT_A with valid `Num` → only one transition, to WAIT_B. `B` stays 0 until a release and a new press occur.
